// File: rtl/btree_switch_pkg.sv
// Shared definitions for the binary-tree NoC switch.
//   - Port indices used to slice the flattened 3-port buses.
//   - route_e: where a FIFO head packet wants to go.
//   - cand_port(): maps (output port, arbiter select bit) to the input port
//     that competes for that output. Select 0 is always the lower-indexed
//     candidate, which is where a freshly reset arbiter points.
package btree_switch_pkg;

  localparam int PORT_LEFT   = 0;
  localparam int PORT_RIGHT  = 1;
  localparam int PORT_PARENT = 2;

  typedef enum logic [1:0] {
    ROUTE_LEFT   = 2'd0,
    ROUTE_RIGHT  = 2'd1,
    ROUTE_PARENT = 2'd2,
    ROUTE_DROP   = 2'd3
  } route_e;

  // An output never takes traffic from its own input port, so each output
  // has exactly two candidates: left {right, parent}, right {left, parent},
  // parent {left, right}.
  function automatic int cand_port(input int out_port, input logic sel);
    case (out_port)
      PORT_LEFT:  return sel ? PORT_PARENT : PORT_RIGHT;
      PORT_RIGHT: return sel ? PORT_PARENT : PORT_LEFT;
      default:    return sel ? PORT_RIGHT  : PORT_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/btree_switch_fifo.sv
// Per-input packet FIFO for btree_switch (module btree_fifo).
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (empties the FIFO)
//   push       - write push_data this cycle (ignored when full)
//   push_data  - packet to store
//   pop        - discard the head this cycle (ignored when empty)
//   full/empty - occupancy flags
//   head       - oldest stored packet, valid whenever !empty
// FifoDepth must be a power of two so the pointers wrap naturally.
module btree_fifo #(
  parameter int TotalWidth = 35,
  parameter int FifoDepth  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [TotalWidth-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [TotalWidth-1:0] head
);

  localparam int PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam logic [PtrWidth-1:0] PtrOne    = PtrWidth'(1);
  localparam logic [PtrWidth:0]   CountOne  = (PtrWidth + 1)'(1);
  localparam logic [PtrWidth:0]   CountFull = (PtrWidth + 1)'(FifoDepth);

  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrWidth:0]     count_q, count_d;
  logic [TotalWidth-1:0] mem_q [FifoDepth];
  logic                  do_push, do_pop;

  assign full  = (count_q == CountFull);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A pop while full does not free a slot for a same-cycle push: push is
  // gated on the registered full flag only.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = do_push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until the count says so.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/btree_switch.sv
// Three-port binary-tree NoC switch (left child, right child, parent).
// Ports (slice 0 = left, 1 = right, 2 = parent on every 3-wide bus):
//   clk, rst      - clock, asynchronous active-high reset
//   i_data        - incoming packets, TotalWidth bits per port
//   i_data_valid  - incoming packet valid per port
//   o_data_ready  - input FIFO has room, per port
//   o_data        - outgoing packets (registered)
//   o_data_valid  - outgoing packet valid per port (registered)
//   i_data_ready  - downstream can accept, per port
// A packet's destination PE is i_data[DataWidth +: AddressWidth]; nothing in
// a packet is ever modified. Packets leave the subtree through the parent
// when their upper address bits differ from Prefix, otherwise bit [Level]
// picks left/right. Each output arbitrates between its two candidate inputs
// with a 1-bit round-robin pointer.
module btree_switch
  import btree_switch_pkg::*;
#(
  parameter int AddressWidth = 2,
  parameter int DataWidth    = 32,
  parameter int TotalWidth   = 35,
  parameter int Level        = 0,
  parameter int Prefix       = 0,
  parameter int FifoDepth    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3*TotalWidth-1:0] i_data,
  input  logic [2:0]              i_data_valid,
  output logic [2:0]              o_data_ready,
  output logic [3*TotalWidth-1:0] o_data,
  output logic [2:0]              o_data_valid,
  input  logic [2:0]              i_data_ready
);

  localparam bit IsRoot = (Level == AddressWidth - 1);

  logic [2:0]              fifo_full, fifo_empty, fifo_pop;
  logic [TotalWidth-1:0]   fifo_head [3];
  logic [AddressWidth-1:0] head_dest [3];
  logic [2:0]              goes_up;
  route_e                  head_route [3];

  logic [2:0]              req_a, req_b, sel_b, load_en;
  logic [2:0]              rr_ptr_q, rr_ptr_d;
  logic [2:0]              out_valid_q, out_valid_d;
  logic [TotalWidth-1:0]   out_data_q [3];
  logic [TotalWidth-1:0]   out_data_d [3];

  for (genvar k = 0; k < 3; k++) begin : g_port
    btree_fifo #(
      .TotalWidth(TotalWidth),
      .FifoDepth (FifoDepth)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (i_data_valid[k] & ~fifo_full[k]),
      .push_data(i_data[k*TotalWidth +: TotalWidth]),
      .pop      (fifo_pop[k]),
      .full     (fifo_full[k]),
      .empty    (fifo_empty[k]),
      .head     (fifo_head[k])
    );

    assign o_data_ready[k] = ~fifo_full[k];
    assign o_data[k*TotalWidth +: TotalWidth] = out_data_q[k];
    assign head_dest[k] = fifo_head[k][DataWidth +: AddressWidth];

    // Shifting out the bits below the subtree boundary leaves exactly the
    // prefix bits; the root owns every address and never sends upward.
    // Parent traffic is always headed down.
    assign goes_up[k] = (k != PORT_PARENT) && !IsRoot &&
                        ((head_dest[k] >> (Level + 1)) != AddressWidth'(Prefix));
  end

  assign o_data_valid = out_valid_q;

  // A child packet that routes back to its own port can only come from a
  // misconfigured tree; it is marked for silent discard.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      head_route[k] = ROUTE_LEFT;
      if (goes_up[k]) begin
        head_route[k] = ROUTE_PARENT;
      end else if (head_dest[k][Level]) begin
        head_route[k] = ROUTE_RIGHT;
      end
      if (k != PORT_PARENT && int'(head_route[k]) == k) begin
        head_route[k] = ROUTE_DROP;
      end
    end
  end

  // Arbitration and output register loading. An output register accepts a
  // new packet whenever it is empty or being drained this cycle, which keeps
  // one packet per cycle per output under continuous ready. Because every
  // head targets one output only, a head can never be granted twice.
  always_comb begin
    fifo_pop    = '0;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    req_a       = '0;
    req_b       = '0;
    sel_b       = '0;
    load_en     = '0;
    for (int op = 0; op < 3; op++) begin
      out_data_d[op] = out_data_q[op];
    end

    for (int k = 0; k < 3; k++) begin
      if (!fifo_empty[k] && head_route[k] == ROUTE_DROP) begin
        fifo_pop[k] = 1'b1;
      end
    end

    for (int op = 0; op < 3; op++) begin
      load_en[op] = ~out_valid_q[op] | i_data_ready[op];
      req_a[op] = ~fifo_empty[cand_port(op, 1'b0)] &&
                  (int'(head_route[cand_port(op, 1'b0)]) == op);
      req_b[op] = ~fifo_empty[cand_port(op, 1'b1)] &&
                  (int'(head_route[cand_port(op, 1'b1)]) == op);
      // Contention follows the pointer; a lone requester wins outright.
      sel_b[op] = (req_a[op] & req_b[op]) ? rr_ptr_q[op] : req_b[op];

      if (load_en[op]) begin
        out_valid_d[op] = req_a[op] | req_b[op];
        if (req_a[op] | req_b[op]) begin
          out_data_d[op] = fifo_head[cand_port(op, sel_b[op])];
          fifo_pop[cand_port(op, sel_b[op])] = 1'b1;
          if (req_a[op] & req_b[op]) begin
            rr_ptr_d[op] = ~rr_ptr_q[op];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      out_valid_q <= '0;
      for (int op = 0; op < 3; op++) begin
        out_data_q[op] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      for (int op = 0; op < 3; op++) begin
        out_data_q[op] <= out_data_d[op];
      end
    end
  end

endmodule

// File: tb/tb_btree_switch.sv
// Self-checking bench for btree_switch: a leaf instance (Level 0) and a root
// instance (Level 1). Directed table vectors and hand-written sequences check
// exact timing and values; a scoreboard tracks every accepted packet and
// matches it against what emerges, per destination port and source.
module tb_btree_switch;

  localparam int TW = 35;
  localparam int L  = 0;
  localparam int R  = 1;
  localparam int P  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3*TW-1:0] in_data0, out_data0, in_data1, out_data1;
  logic [2:0]      in_valid0, rdy0, out_valid0, ds_ready0;
  logic [2:0]      in_valid1, rdy1, out_valid1, ds_ready1;

  btree_switch #(
    .AddressWidth(2), .DataWidth(32), .TotalWidth(TW),
    .Level(0), .Prefix(0), .FifoDepth(4)
  ) dut0 (
    .clk(clk), .rst(rst),
    .i_data(in_data0), .i_data_valid(in_valid0), .o_data_ready(rdy0),
    .o_data(out_data0), .o_data_valid(out_valid0), .i_data_ready(ds_ready0)
  );

  btree_switch #(
    .AddressWidth(2), .DataWidth(32), .TotalWidth(TW),
    .Level(1), .Prefix(0), .FifoDepth(4)
  ) dut1 (
    .clk(clk), .rst(rst),
    .i_data(in_data1), .i_data_valid(in_valid1), .o_data_ready(rdy1),
    .o_data(out_data1), .o_data_valid(out_valid1), .i_data_ready(ds_ready1)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          dut;
    int          port;
    logic [TW-1:0] pkt;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    int            src;
    logic [TW-1:0] pkt;
    int            exp_port;
  } vec_t;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source id lives in data[27:24] so the scoreboard can keep per-source order.
  function automatic logic [TW-1:0] mk_pkt(input int src, input int dest, input int seq);
    logic [31:0] d;
    d = {4'hC, 4'(src), 8'(seq), 16'(seq) ^ 16'h5A5A};
    return {1'(seq & 1), 2'(dest), d};
  endfunction

  // Reference routing for 2-bit addresses with Prefix 0; returns 3 for a
  // packet that must be discarded.
  function automatic int route_model(input int level, input int src, input logic [1:0] dest);
    int port;
    if (src != P && level < 1 && dest[1] != 1'b0) port = P;
    else port = dest[level] ? R : L;
    if (src != P && port == src) port = 3;
    return port;
  endfunction

  function automatic int sbCount(input int d);
    int n = 0;
    foreach (sb[i]) if (sb[i].dut == d) n++;
    return n;
  endfunction

  task automatic monitorDut(input int d, input int level,
                            input logic [3*TW-1:0] idata, input logic [2:0] ivalid,
                            input logic [2:0] irdy, input logic [3*TW-1:0] odata,
                            input logic [2:0] ovalid, input logic [2:0] oready);
    for (int op = 0; op < 3; op++) begin
      if (ovalid[op] && oready[op]) begin
        logic [TW-1:0] got;
        logic [TW-1:0] cand;
        int idx;
        got = odata[op*TW +: TW];
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          cand = sb[i].pkt;
          if (idx < 0 && sb[i].dut == d && sb[i].port == op && cand[27:24] == got[27:24]) idx = i;
        end
        if (idx < 0) begin
          total++;
          bad++;
          $display("[TB] FAIL sb_unexpected dut%0d port%0d: got %0h expected none", d, op, got);
        end else begin
          checkOutput($sformatf("sb_dut%0d_port%0d", d, op), 64'(got), 64'(sb[idx].pkt));
          sb.delete(idx);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (ivalid[k] && irdy[k]) begin
        logic [TW-1:0] p;
        int port;
        p = idata[k*TW +: TW];
        port = route_model(level, k, p[33:32]);
        if (port != 3) sb.push_back('{dut: d, port: port, pkt: p});
      end
    end
  endtask

  // Transfers are decided by the values stable at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      monitorDut(0, 0, in_data0, in_valid0, rdy0, out_data0, out_valid0, ds_ready0);
      monitorDut(1, 1, in_data1, in_valid1, rdy1, out_data1, out_valid1, ds_ready1);
    end
  end

  // Single packet through the leaf: nothing valid before edge N+1, exactly
  // the expected port valid after it, with the packet unmodified.
  task automatic applyStimulus(input vec_t v, input int idx);
    in_data0[v.src*TW +: TW] = v.pkt;
    in_valid0[v.src] = 1'b1;
    @(posedge clk); #1;
    in_valid0 = '0;
    @(negedge clk);
    checkOutput($sformatf("vec%0d_early_valid", idx), 64'(out_valid0), 64'(0));
    @(posedge clk);
    @(negedge clk);
    for (int op = 0; op < 3; op++) begin
      checkOutput($sformatf("vec%0d_valid%0d", idx, op), 64'(out_valid0[op]), 64'(op == v.exp_port));
      if (op == v.exp_port)
        checkOutput($sformatf("vec%0d_data%0d", idx, op), 64'(out_data0[op*TW +: TW]), 64'(v.pkt));
    end
    checkOutput($sformatf("vec%0d_ready", idx), 64'(rdy0), 64'(3'b111));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    vec_t vecs[11];
    int accepted;
    int seq;
    logic acc;
    logic [TW-1:0] exp_order[10];
    int sent;
    logic [2:0] hold;
    int dest;

    vecs[0]  = '{src: L, pkt: {1'b0, 2'b01, 32'h0000_00AA}, exp_port: R};
    vecs[1]  = '{src: L, pkt: mk_pkt(L, 2, 1), exp_port: P};
    vecs[2]  = '{src: L, pkt: mk_pkt(L, 3, 2), exp_port: P};
    vecs[3]  = '{src: R, pkt: mk_pkt(R, 0, 3), exp_port: L};
    vecs[4]  = '{src: R, pkt: mk_pkt(R, 2, 4), exp_port: P};
    vecs[5]  = '{src: P, pkt: mk_pkt(P, 0, 5), exp_port: L};
    vecs[6]  = '{src: P, pkt: mk_pkt(P, 1, 6), exp_port: R};
    vecs[7]  = '{src: P, pkt: mk_pkt(P, 2, 7), exp_port: L};
    vecs[8]  = '{src: P, pkt: mk_pkt(P, 3, 8), exp_port: R};
    vecs[9]  = '{src: L, pkt: mk_pkt(L, 0, 9), exp_port: 3};
    vecs[10] = '{src: R, pkt: mk_pkt(R, 1, 10), exp_port: 3};

    rst = 1'b1;
    in_data0 = '0; in_valid0 = '0; ds_ready0 = 3'b111;
    in_data1 = '0; in_valid1 = '0; ds_ready1 = 3'b111;
    #2;
    checkOutput("rst_valid0", 64'(out_valid0), 64'(0));
    checkOutput("rst_valid1", 64'(out_valid1), 64'(0));
    for (int op = 0; op < 3; op++)
      checkOutput($sformatf("rst_data%0d", op), 64'(out_data0[op*TW +: TW]), 64'(0));
    #10;
    rst = 1'b0;
    #1;
    checkOutput("rst_ready0", 64'(rdy0), 64'(3'b111));
    checkOutput("rst_ready1", 64'(rdy1), 64'(3'b111));
    @(posedge clk); #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

    $display("[TB] up route with round-robin");
    for (int i = 0; i < 5; i++) begin
      exp_order[2*i]   = mk_pkt(L, 2, 16 + i);
      exp_order[2*i+1] = mk_pkt(R, 3, 16 + i);
    end
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          in_data0[L*TW +: TW] = mk_pkt(L, 2, 16 + i);
          in_data0[R*TW +: TW] = mk_pkt(R, 3, 16 + i);
          in_valid0 = 3'b011;
          @(posedge clk); #1;
        end
        in_valid0 = '0;
      end
      begin
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
          @(posedge clk);
          @(negedge clk);
          checkOutput($sformatf("up_valid_%0d", i), 64'(out_valid0[P]), 64'(1));
          checkOutput($sformatf("up_data_%0d", i), 64'(out_data0[P*TW +: TW]), 64'(exp_order[i]));
        end
      end
    join
    @(posedge clk); #1;

    $display("[TB] backpressure on parent output");
    accepted = 0;
    seq = 0;
    ds_ready0[P] = 1'b0;
    in_data0[L*TW +: TW] = mk_pkt(L, 2, 32);
    in_valid0[L] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      acc = rdy0[L];
      checkOutput($sformatf("bp_hold_valid_%0d", i), 64'(out_valid0[P]), 64'(i >= 2));
      if (i >= 2)
        checkOutput($sformatf("bp_hold_data_%0d", i), 64'(out_data0[P*TW +: TW]), 64'(mk_pkt(L, 2, 32)));
      @(posedge clk); #1;
      if (acc) begin
        accepted++;
        seq++;
        in_data0[L*TW +: TW] = mk_pkt(L, 2, 32 + seq);
      end
    end
    checkOutput("bp_accepted", 64'(accepted), 64'(5));
    checkOutput("bp_ready_low", 64'(rdy0[L]), 64'(0));
    in_valid0 = '0;
    ds_ready0[P] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_drain_valid_%0d", j), 64'(out_valid0[P]), 64'(1));
      checkOutput($sformatf("bp_drain_data_%0d", j), 64'(out_data0[P*TW +: TW]), 64'(mk_pkt(L, 2, 32 + j)));
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("bp_drained", 64'(out_valid0[P]), 64'(0));
    @(posedge clk); #1;

    $display("[TB] reset mid-operation");
    ds_ready0 = '0;
    in_data0 = {mk_pkt(P, 1, 48), mk_pkt(R, 0, 49), mk_pkt(L, 2, 50)};
    in_valid0 = 3'b111;
    @(posedge clk); #1;
    in_valid0 = '0;
    @(posedge clk); #3;
    checkOutput("mid_loaded", 64'(out_valid0), 64'(3'b111));
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 64'(out_valid0), 64'(0));
    for (int op = 0; op < 3; op++)
      checkOutput($sformatf("mid_rst_data%0d", op), 64'(out_data0[op*TW +: TW]), 64'(0));
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checkOutput("mid_ready", 64'(rdy0), 64'(3'b111));
    ds_ready0 = 3'b111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mid_no_stale_%0d", i), 64'(out_valid0), 64'(0));
    end
    @(posedge clk); #1;

    $display("[TB] parent traffic");
    in_data0[P*TW +: TW] = mk_pkt(P, 0, 64);
    in_data0[R*TW +: TW] = mk_pkt(R, 0, 65);
    in_valid0 = 3'b110;
    @(posedge clk); #1;
    in_data0[P*TW +: TW] = mk_pkt(P, 1, 66);
    in_valid0 = 3'b100;
    @(posedge clk); #1;
    in_valid0 = '0;
    @(negedge clk);
    checkOutput("par_left_first", 64'(out_data0[L*TW +: TW]), 64'(mk_pkt(R, 0, 65)));
    checkOutput("par_valid_1", 64'(out_valid0), 64'(3'b001));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("par_left_second", 64'(out_data0[L*TW +: TW]), 64'(mk_pkt(P, 0, 64)));
    checkOutput("par_valid_2", 64'(out_valid0), 64'(3'b001));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("par_right", 64'(out_data0[R*TW +: TW]), 64'(mk_pkt(P, 1, 66)));
    checkOutput("par_valid_3", 64'(out_valid0), 64'(3'b010));
    @(posedge clk); #1;

    $display("[TB] root switch");
    in_data1[R*TW +: TW] = mk_pkt(R, 0, 80);
    in_data1[P*TW +: TW] = mk_pkt(P, 2, 81);
    in_valid1 = 3'b110;
    @(posedge clk); #1;
    in_valid1 = '0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("root_r_to_left", 64'(out_data1[L*TW +: TW]), 64'(mk_pkt(R, 0, 80)));
    checkOutput("root_p_to_right", 64'(out_data1[R*TW +: TW]), 64'(mk_pkt(P, 2, 81)));
    checkOutput("root_valid", 64'(out_valid1), 64'(3'b011));
    @(posedge clk); #1;

    sent = 0;
    hold = '0;
    for (int cyc = 0; cyc < 2000 && (sent < 100 || hold != 0); cyc++) begin
      for (int k = 0; k < 3; k++) begin
        if (!hold[k] && sent < 100 && $urandom_range(0, 1) == 1) begin
          if (k == L)      dest = 2 + $urandom_range(0, 1);
          else if (k == R) dest = $urandom_range(0, 1);
          else             dest = $urandom_range(0, 3);
          in_data1[k*TW +: TW] = mk_pkt(k, dest, 100 + sent);
          hold[k] = 1'b1;
          sent++;
        end
      end
      in_valid1 = hold;
      for (int k = 0; k < 3; k++) ds_ready1[k] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checkOutput("root_parent_idle", 64'(out_valid1[P]), 64'(0));
      for (int k = 0; k < 3; k++) if (hold[k] && rdy1[k]) hold[k] = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput("root_all_sent", 64'(sent), 64'(100));
    checkOutput("root_all_accepted", 64'(hold), 64'(0));
    in_valid1 = '0;
    ds_ready1 = 3'b111;
    for (int c = 0; c < 200 && sbCount(1) != 0; c++) begin
      @(negedge clk);
      checkOutput("root_drain_parent_idle", 64'(out_valid1[P]), 64'(0));
    end
    @(posedge clk); #1;
    checkOutput("root_drained", 64'(sbCount(1)), 64'(0));
    checkOutput("sb_leftover", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
